// File: rtl/l2_burst_responder_pkg.sv
// Shared types and constants for the L2 line-to-burst responder.
// Imported by the interface, the line buffer and the top-level FSM.
package l2_burst_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    // A line is 32 bytes, so the burst base simply clears the byte offset.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~32'h0000_001F;
    endfunction

endpackage

// File: rtl/l2_burst_responder_if.sv
// Line-request side and burst-memory side of the responder, bundled together.
// slave: the responder itself; master: the arbiter plus memory model around it.
interface l2_burst_responder_if #(
    parameter int LINE_WIDTH = l2_burst_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH = l2_burst_pkg::BEAT_WIDTH
);

    logic                  line_read;
    logic                  line_write;
    logic [31:0]           line_addr;
    logic [LINE_WIDTH-1:0] line_wdata;
    logic                  line_resp;
    logic [LINE_WIDTH-1:0] line_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_addr;
    logic [BEAT_WIDTH-1:0] mem_wdata;
    logic [BEAT_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  line_read, line_write, line_addr, line_wdata,
        output line_resp, line_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output line_read, line_write, line_addr, line_wdata,
        input  line_resp, line_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/l2_burst_responder_line_beat_buffer.sv
// One cache line of storage, loadable whole or one beat at a time,
// with a beat-select read port for streaming write bursts out.
module line_beat_buffer #(
    parameter int LINE_WIDTH = l2_burst_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH = l2_burst_pkg::BEAT_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     load,
    input  logic [LINE_WIDTH-1:0]                    load_data,
    input  logic                                     beat_we,
    input  logic [$clog2(LINE_WIDTH/BEAT_WIDTH)-1:0] beat_idx,
    input  logic [BEAT_WIDTH-1:0]                    beat_wdata,
    output logic [LINE_WIDTH-1:0]                    line_q,
    output logic [BEAT_WIDTH-1:0]                    beat_q
);

    // NOTE: this storage is reset on purpose; line_rdata and mem_wdata are
    // read straight from it and must come up as zero, so it is not left
    // uninitialised the way a plain data array would be.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_data;
        end else if (beat_we) begin
            line_q[int'(beat_idx)*BEAT_WIDTH +: BEAT_WIDTH] <= beat_wdata;
        end
    end

    assign beat_q = line_q[int'(beat_idx)*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/l2_burst_responder.sv
// Serves one full-line read or write as a fixed four-beat burst on the
// physical-memory port; a single outstanding request at a time.
module l2_burst_responder #(
    parameter int LINE_WIDTH = l2_burst_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH = l2_burst_pkg::BEAT_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    l2_burst_responder_if.slave bus
);

    import l2_burst_pkg::*;

    localparam int                  IDX_W     = $clog2(LINE_WIDTH / BEAT_WIDTH);
    localparam logic [IDX_W-1:0]    LAST_BEAT = IDX_W'(LINE_WIDTH / BEAT_WIDTH - 1);

    state_t            state;
    logic [IDX_W-1:0]  k;
    logic              line_resp_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [31:0]       mem_addr_q;

    logic                  buf_load;
    logic                  buf_beat_we;
    logic [LINE_WIDTH-1:0] buf_line;
    logic [BEAT_WIDTH-1:0] buf_beat;

    // Write data is captured only on the IDLE exit; later changes are ignored.
    assign buf_load    = (state == IDLE) && bus.line_write;
    assign buf_beat_we = (state == READ) && bus.mem_resp;

    line_beat_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_data  (bus.line_wdata),
        .beat_we    (buf_beat_we),
        .beat_idx   (k),
        .beat_wdata (bus.mem_rdata),
        .line_q     (buf_line),
        .beat_q     (buf_beat)
    );

    // NOTE: every register below is updated with <= so all of them see the
    // pre-edge values of state and k; blocking updates here would let the
    // counter and state race each other within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            line_resp_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.line_write || bus.line_read) begin
                        mem_addr_q <= line_base(bus.line_addr);
                        k          <= '0;
                        if (bus.line_write) begin
                            state       <= WRITE;
                            mem_write_q <= 1'b1;
                        end else begin
                            state      <= READ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                READ, WRITE: begin
                    if (bus.mem_resp) begin
                        // k holds at the last beat; it is only cleared on the next IDLE exit.
                        if (k == LAST_BEAT) begin
                            state       <= RESP;
                            mem_read_q  <= 1'b0;
                            mem_write_q <= 1'b0;
                            line_resp_q <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                RESP: begin
                    line_resp_q <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.line_resp  = line_resp_q;
    assign bus.line_rdata = buf_line;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = buf_beat;

endmodule

// File: tb/tb_l2_burst_responder.sv
// Randomised bench for l2_burst_responder: a requester and burst memory are
// modelled at transaction level and every cycle's outputs are checked.
module tb_l2_burst_responder;

    import l2_burst_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    l2_burst_responder_if #(.LINE_WIDTH(LINE_WIDTH), .BEAT_WIDTH(BEAT_WIDTH)) bus ();

    l2_burst_responder #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic expect_idle_outputs(input string name, input bit all_zero);
        n_tests++;
        if (bus.line_resp !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: resp/rd/wr=%b%b%b required 000", name,
                     bus.line_resp, bus.mem_read, bus.mem_write);
        end
        if (all_zero) begin
            n_tests++;
            if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== '0 || bus.line_rdata !== '0) begin
                n_fail++;
                $display("FAIL %s: mem_addr=%h mem_wdata=%h line_rdata=%h required all zero",
                         name, bus.mem_addr, bus.mem_wdata, bus.line_rdata);
            end
        end
    endtask

    // One transaction, from request presentation to the IDLE cycle after RESP.
    // Memory side: beats come from 'line' in order 0..3 whenever mem_resp is 1.
    task automatic do_burst(input string name, input bit wr, input bit both,
                            input logic [31:0] addr, input logic [255:0] line,
                            input bit use_mask, input logic [31:0] mask,
                            input bit hold, input bit poke);
        logic [31:0] exp_addr;
        int beats, cyc;
        bit r;
        exp_addr = {addr[31:5], 5'b0};
        bus.line_write = wr;
        bus.line_read  = !wr || both;
        bus.line_addr  = addr;
        bus.line_wdata = wr ? line : rand_line();
        bus.mem_resp   = 1'b0;
        @(posedge clk); #1;
        beats = 0;
        cyc   = 0;
        while (beats < 4 && cyc < 64) begin
            if (poke) begin
                bus.line_addr  = ~addr;
                bus.line_wdata = ~line;
            end
            r = use_mask ? mask[cyc] : ($urandom_range(0, 2) != 0);
            bus.mem_resp  = r;
            bus.mem_rdata = r ? line[beats*64 +: 64] : {$urandom, $urandom};
            @(negedge clk);
            n_tests++;
            if (bus.mem_read !== !wr || bus.mem_write !== wr || bus.line_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL %s beat-cycle %0d: rd/wr/resp=%b%b%b required %b%b0", name, cyc,
                         bus.mem_read, bus.mem_write, bus.line_resp, !wr, wr);
            end
            n_tests++;
            if (bus.mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL %s mem_addr: got %h required %h", name, bus.mem_addr, exp_addr);
            end
            if (wr) begin
                n_tests++;
                if (bus.mem_wdata !== line[beats*64 +: 64]) begin
                    n_fail++;
                    $display("FAIL %s mem_wdata beat %0d: got %h required %h", name, beats,
                             bus.mem_wdata, line[beats*64 +: 64]);
                end
            end
            if (r) beats++;
            cyc++;
            @(posedge clk); #1;
        end
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
        if (beats < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: only %0d beats in %0d cycles", name, beats, cyc);
            bus.line_read  = 1'b0;
            bus.line_write = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        // RESP cycle: one cycle after the fourth beat.
        @(negedge clk);
        n_tests++;
        if (bus.line_resp !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s resp cycle: resp/rd/wr=%b%b%b required 100", name,
                     bus.line_resp, bus.mem_read, bus.mem_write);
        end
        if (!wr) begin
            n_tests++;
            if (bus.line_rdata !== line) begin
                n_fail++;
                $display("FAIL %s line_rdata: got %h required %h", name, bus.line_rdata, line);
            end
        end
        if (!hold) begin
            bus.line_read  = 1'b0;
            bus.line_write = 1'b0;
        end
        @(posedge clk); #1;
        @(negedge clk);
        expect_idle_outputs({name, " idle-after-resp"}, 1'b0);
    endtask

    task automatic test_reset();
        bus.line_read  = 1'b1;
        bus.line_write = 1'b0;
        bus.line_addr  = 32'hFFFF_FFFF;
        bus.line_wdata = '0;
        bus.mem_resp   = 1'b1;
        bus.mem_rdata  = '1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_idle_outputs("reset held", 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.line_read = 1'b0;
        bus.mem_resp  = 1'b0;
        @(negedge clk);
        expect_idle_outputs("after reset", 1'b1);
    endtask

    task automatic test_read_basic();
        logic [255:0] line;
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_burst("read basic", 1'b0, 1'b0, 32'h0000_1234, line, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_write_basic();
        logic [255:0] line;
        line = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        do_burst("write basic", 1'b1, 1'b0, 32'h8000_0040, line, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_burst("read stalled", 1'b0, 1'b0, 32'h1357_9BDF, rand_line(), 1'b1, 32'h0000_0059,
                 1'b0, 1'b0);
    endtask

    task automatic test_both_high();
        do_burst("both high", 1'b1, 1'b1, 32'h4000_00A0, rand_line(), 1'b1, 32'h0000_00F6,
                 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] line;
        line = rand_line();
        bus.line_read  = 1'b1;
        bus.line_write = 1'b0;
        bus.line_addr  = 32'h0000_2468;
        bus.mem_resp   = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = line[b*64 +: 64];
            @(posedge clk); #1;
        end
        bus.mem_resp = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_2460) begin
            n_fail++;
            $display("FAIL mid-burst before reset: mem_read=%b mem_addr=%h required 1/00002460",
                     bus.mem_read, bus.mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.line_read = 1'b0;
        @(negedge clk);
        expect_idle_outputs("after mid-burst reset", 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            expect_idle_outputs("quiet after reset", 1'b0);
        end
        do_burst("read after reset", 1'b0, 1'b0, 32'h0000_3300, rand_line(), 1'b0, 32'h0,
                 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_burst("b2b data read", 1'b0, 1'b0, 32'h0001_0020, rand_line(), 1'b1, 32'hFFFF_FFFF,
                 1'b1, 1'b0);
        do_burst("b2b instr read", 1'b0, 1'b0, 32'h0002_0FE0, rand_line(), 1'b1, 32'hFFFF_FFFF,
                 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            do_burst("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     rand_line(), 1'b0, 32'h0, (i < 15) && ($urandom_range(0, 1) == 1),
                     1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        bus.line_addr  = '0;
        bus.line_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;
        test_reset();
        test_read_basic();
        test_write_basic();
        test_stall();
        test_both_high();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
